// File: rtl/ras_pkg.sv
// Shared configuration and types for the multi-thread checkpointed return-address stack.
package ras_pkg;

  localparam int WIDTH       = 31;
  localparam int DEPTH       = 16;
  localparam int NUM_THREADS = 2;
  localparam int CKPT_DEPTH  = 8;
  localparam int ADDR        = $clog2(DEPTH);
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CW          = $clog2(CKPT_DEPTH);

  // One extra bit lets head/tail distinguish full from empty.
  function automatic int ckpt_ptr_w();
    return CW + 1;
  endfunction

  function automatic int mem_idx_w();
    return TW + ADDR;
  endfunction

  typedef struct packed {
    logic [ADDR-1:0]  tosp;
    logic [ADDR:0]    count;
    logic [WIDTH-1:0] top;
  } ras_ckpt_t;

  typedef struct packed {
    logic [ADDR-1:0] tosp;
    logic [ADDR:0]   count;
  } ras_thread_t;

endpackage

// File: rtl/ras_ckpt_queue.sv
// Circular checkpoint FIFO for one thread: allocate at tail, retire at head,
// truncate tail back to just past a restored slot.
module ras_ckpt_queue
  import ras_pkg::*;
(
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            alloc_i,
  input  ras_ckpt_t       alloc_data_i,
  input  logic            commit_i,
  input  logic            restore_i,
  input  logic [CW-1:0]   restore_id_i,
  output logic            alloc_ok_o,
  output logic [CW-1:0]   alloc_id_o,
  output logic            full_o,
  output logic            id_valid_o,
  output ras_ckpt_t       restore_data_o
);

  localparam int PW = ckpt_ptr_w();

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, occ, off;
  logic          empty;
  ras_ckpt_t     slot_q [CKPT_DEPTH];

  assign occ            = tail_q - head_q;
  assign full_o         = (occ == PW'(CKPT_DEPTH));
  assign empty          = (occ == '0);
  // Distance of the requested slot from head; live slots satisfy off < occ.
  assign off            = {1'b0, restore_id_i - head_q[CW-1:0]};
  assign id_valid_o     = (off < occ);
  assign alloc_ok_o     = alloc_i && !full_o;
  assign alloc_id_o     = tail_q[CW-1:0];
  assign restore_data_o = slot_q[restore_id_i];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (commit_i && !empty) head_d = head_q + PW'(1);
    if (restore_i) begin
      if (id_valid_o) tail_d = head_q + off + PW'(1);
    end else if (alloc_ok_o) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (clr_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok_o && !restore_i) slot_q[alloc_id_o] <= alloc_data_i;
  end

`ifndef SYNTHESIS
  a_commit_nonempty: assert property (@(posedge clk) disable iff (!rst_ni || clr_i)
    commit_i |-> !empty);
  a_restore_in_range: assert property (@(posedge clk) disable iff (!rst_ni || clr_i)
    restore_i |-> id_valid_o);
`endif

endmodule

// File: rtl/ras_mt_ckpt.sv
// Multi-thread speculative return-address stack with per-thread checkpoint
// queues; restore rewinds pointers and repairs the entry that was on top.
module ras_mt_ckpt
  import ras_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   rst_i,
  input  logic [TW-1:0]          tid_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   valid_o,
  input  logic                   ckpt_i,
  output logic                   ckpt_ok_o,
  output logic [CW-1:0]          ckpt_id_o,
  output logic [NUM_THREADS-1:0] ckpt_full_o,
  input  logic                   commit_i,
  input  logic [TW-1:0]          commit_tid_i,
  input  logic                   restore_i,
  input  logic [TW-1:0]          restore_tid_i,
  input  logic [CW-1:0]          restore_id_i
);

  localparam int MW = mem_idx_w();

  function automatic logic [MW-1:0] idx(input logic [TW-1:0] t, input logic [ADDR-1:0] a);
    return {t, a};
  endfunction

  ras_thread_t      st_q [NUM_THREADS];
  ras_thread_t      st_d [NUM_THREADS];
  logic [WIDTH-1:0] mem_q [NUM_THREADS*DEPTH];

  logic [NUM_THREADS-1:0] sel, rs, psh, pp, ck_req, cm, ok, idv, we;
  logic [ADDR-1:0]        waddr [NUM_THREADS];
  logic [WIDTH-1:0]       wdata [NUM_THREADS];
  ras_ckpt_t              ckd   [NUM_THREADS];
  ras_ckpt_t              rdata [NUM_THREADS];
  logic [CW-1:0]          id_a  [NUM_THREADS];
  ras_thread_t            cur;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      sel[t]    = (tid_i == TW'(t));
      rs[t]     = restore_i && (restore_tid_i == TW'(t));
      psh[t]    = push_i && sel[t] && !rs[t];
      pp[t]     = pop_i && sel[t] && !rs[t];
      ck_req[t] = ckpt_i && sel[t] && !rs[t];
      cm[t]     = commit_i && (commit_tid_i == TW'(t));
      st_d[t]   = st_q[t];
      we[t]     = 1'b0;
      waddr[t]  = st_q[t].tosp;
      wdata[t]  = din_i;
      if (rs[t]) begin
        if (idv[t]) begin
          st_d[t].tosp  = rdata[t].tosp;
          st_d[t].count = rdata[t].count;
          we[t]         = 1'b1;
          waddr[t]      = rdata[t].tosp;
          wdata[t]      = rdata[t].top;
        end
      end else if (psh[t] && pp[t]) begin
        // Tail call replaces the top; an empty stack behaves like a push.
        if (st_q[t].count == '0) begin
          st_d[t].tosp  = st_q[t].tosp + ADDR'(1);
          st_d[t].count = (ADDR+1)'(1);
        end
        we[t]    = 1'b1;
        waddr[t] = st_d[t].tosp;
      end else if (psh[t]) begin
        st_d[t].tosp = st_q[t].tosp + ADDR'(1);
        if (st_q[t].count != (ADDR+1)'(DEPTH)) st_d[t].count = st_q[t].count + (ADDR+1)'(1);
        we[t]    = 1'b1;
        waddr[t] = st_d[t].tosp;
      end else if (pp[t] && st_q[t].count != '0) begin
        st_d[t].tosp  = st_q[t].tosp - ADDR'(1);
        st_d[t].count = st_q[t].count - (ADDR+1)'(1);
      end
      // Snapshot reflects this cycle's push/pop, so forward din_i when written.
      ckd[t].tosp  = st_d[t].tosp;
      ckd[t].count = st_d[t].count;
      ckd[t].top   = we[t] ? din_i : mem_q[idx(TW'(t), st_d[t].tosp)];
    end
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_q
    ras_ckpt_queue u_q (
      .clk            (clk),
      .rst_ni         (rst_ni),
      .clr_i          (rst_i),
      .alloc_i        (ck_req[g]),
      .alloc_data_i   (ckd[g]),
      .commit_i       (cm[g]),
      .restore_i      (rs[g]),
      .restore_id_i   (restore_id_i),
      .alloc_ok_o     (ok[g]),
      .alloc_id_o     (id_a[g]),
      .full_o         (ckpt_full_o[g]),
      .id_valid_o     (idv[g]),
      .restore_data_o (rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NUM_THREADS; t++) st_q[t] <= '0;
    end else if (rst_i) begin
      for (int t = 0; t < NUM_THREADS; t++) st_q[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) st_q[t] <= st_d[t];
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (we[t] && !rst_i) mem_q[idx(TW'(t), waddr[t])] <= wdata[t];
    end
  end

  assign cur       = st_q[tid_i];
  assign valid_o   = (cur.count != '0);
  assign dout_o    = valid_o ? mem_q[idx(tid_i, cur.tosp)] : '0;
  assign ckpt_ok_o = (|ok) && !rst_i;
  assign ckpt_id_o = id_a[tid_i];

endmodule
